// File: rtl/model_controller_pkg.sv
// Shared types and sizing helpers for the model_controller block family.
package model_controller_pkg;

  localparam int unsigned DATA_SIZE_DEF = 64;
  localparam int unsigned L_MAX_DEF     = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPLAY  = 2'd2
  } state_t;

  // One extra bit over the address width so a full-depth count is representable.
  function automatic int unsigned idx_width(input int unsigned l_max);
    return $clog2(l_max) + 1;
  endfunction

endpackage

// File: rtl/model_controller_h_feedback_if.sv
// Handshake/data bundle between model_controller and its hidden-state feedback stage.
interface model_controller_h_feedback_if
  import model_controller_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
);

  logic                 START;
  logic                 READY;
  logic                 ERROR;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic                 H_OUT_ENABLE;
  logic [DATA_SIZE-1:0] H_OUT;
  logic                 H_IN_ENABLE;
  logic [DATA_SIZE-1:0] H_IN;
  logic                 H_IN_READY;

  modport master (
    output START, SIZE_L_IN, H_OUT_ENABLE, H_OUT, H_IN_READY,
    input  READY, ERROR, H_IN_ENABLE, H_IN
  );

  modport slave (
    input  START, SIZE_L_IN, H_OUT_ENABLE, H_OUT, H_IN_READY,
    output READY, ERROR, H_IN_ENABLE, H_IN
  );

endinterface

// File: rtl/model_controller_h_feedback_buffer.sv
// Hidden-vector store: synchronous write port, combinational read port.
module model_controller_h_feedback_buffer #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AW        = 6
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/model_controller_h_feedback.sv
// Captures the H_OUT vector of step t and replays it onto H_IN for step t+1.
module model_controller_h_feedback
  import model_controller_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = DATA_SIZE_DEF,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned L_MAX        = L_MAX_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  model_controller_h_feedback_if.slave  bus
);

  localparam int unsigned IW = idx_width(L_MAX);
  localparam int unsigned AW = (L_MAX > 1) ? $clog2(L_MAX) : 1;
  localparam logic [DATA_SIZE-1:0] L_MAX_W = DATA_SIZE'(L_MAX);
  localparam logic [IW-1:0]        IDX_ONE = IW'(1);

  // The control word is carried only so this block shares the family's parameter list.
  if (CONTROL_SIZE == 0) begin : g_no_control_word
  end

  state_t               state, state_n;
  logic [IW-1:0]        index, index_n;
  logic [IW-1:0]        size, size_n;
  logic [IW-1:0]        last_idx;
  logic                 ready_q, ready_n;
  logic                 error_q, error_n;
  logic                 en_q, en_n;
  logic [DATA_SIZE-1:0] h_in_q, h_in_n;
  logic [DATA_SIZE-1:0] rd_data;
  logic [AW-1:0]        rd_addr;
  logic                 wr_en;
  logic                 size_ok;

  assign last_idx = size - IDX_ONE;
  // Full-width compare so oversize requests are rejected rather than truncated.
  assign size_ok  = (bus.SIZE_L_IN != '0) && (bus.SIZE_L_IN <= L_MAX_W);
  assign rd_addr  = (state == REPLAY) ? index[AW-1:0] + AW'(1) : '0;

  model_controller_h_feedback_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (L_MAX),
    .AW        (AW)
  ) u_buffer (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (index[AW-1:0]),
    .wr_data (bus.H_OUT),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      index   <= '0;
      size    <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      h_in_q  <= '0;
    end else begin
      state   <= state_n;
      index   <= index_n;
      size    <= size_n;
      ready_q <= ready_n;
      error_q <= error_n;
      en_q    <= en_n;
      h_in_q  <= h_in_n;
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    size_n  = size;
    ready_n = 1'b0;
    error_n = 1'b0;
    en_n    = en_q;
    h_in_n  = h_in_q;
    wr_en   = 1'b0;

    case (state)
      IDLE: begin
        en_n   = 1'b0;
        h_in_n = '0;
        if (bus.START) begin
          if (size_ok) begin
            size_n  = bus.SIZE_L_IN[IW-1:0];
            index_n = '0;
            state_n = CAPTURE;
          end else begin
            error_n = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (bus.H_OUT_ENABLE) begin
          wr_en = 1'b1;
          if (index == last_idx) begin
            index_n = '0;
            state_n = REPLAY;
            en_n    = 1'b1;
            // With L=1 element 0 is being written this very edge, so forward it.
            h_in_n  = (index == '0) ? bus.H_OUT : rd_data;
          end else begin
            index_n = index + IDX_ONE;
          end
        end
      end

      REPLAY: begin
        if (en_q && bus.H_IN_READY) begin
          if (index == last_idx) begin
            index_n = '0;
            state_n = IDLE;
            en_n    = 1'b0;
            h_in_n  = '0;
            ready_n = 1'b1;
          end else begin
            index_n = index + IDX_ONE;
            h_in_n  = rd_data;
          end
        end
      end

      default: begin
        state_n = IDLE;
        index_n = '0;
        en_n    = 1'b0;
        h_in_n  = '0;
      end
    endcase
  end

  assign bus.READY       = ready_q;
  assign bus.ERROR       = error_q;
  assign bus.H_IN_ENABLE = en_q;
  assign bus.H_IN        = h_in_q;

endmodule

// File: tb/tb_model_controller_h_feedback.sv
// Bench for the hidden-state feedback stage: directed tables, corner sequences, random runs.
module tb_model_controller_h_feedback;

  localparam int unsigned DW = 64;
  localparam int unsigned LM = 64;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  model_controller_h_feedback_if #(.DATA_SIZE(DW)) bus ();

  model_controller_h_feedback #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (64),
    .L_MAX        (LM)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    logic [63:0] size;
    bit          exp_error;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.START        = 1'b0;
    bus.SIZE_L_IN    = '0;
    bus.H_OUT_ENABLE = 1'b0;
    bus.H_OUT        = {$urandom, $urandom};
    bus.H_IN_READY   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.READY), 64'd0);
    check({tag, "_error"}, 64'(bus.ERROR), 64'd0);
    check({tag, "_en"},    64'(bus.H_IN_ENABLE), 64'd0);
    check({tag, "_hin"},   bus.H_IN, 64'd0);
  endtask

  // Reference: the replay must reproduce the captured elements in capture order,
  // one per accepted handshake, with READY on the cycle after the final transfer.
  task automatic run(input int unsigned L, input logic [63:0] data[$], input bit en_pat[$],
                     input bit rdy_pat[$], input bit rand_rdy, input bit poke_start);
    int unsigned n;
    int unsigned j;
    int unsigned k;
    int unsigned cyc;
    bit r;
    bus.START     = 1'b1;
    bus.SIZE_L_IN = 64'(L);
    tick();
    check("start_ready_low", 64'(bus.READY), 64'd0);
    check("start_no_error", 64'(bus.ERROR), 64'd0);
    check("start_en_low", 64'(bus.H_IN_ENABLE), 64'd0);
    bus.START = 1'b0;
    n = 0;
    for (int i = 0; i < en_pat.size(); i++) begin
      bus.H_OUT_ENABLE = en_pat[i];
      bus.H_OUT        = en_pat[i] ? data[n] : {$urandom, $urandom};
      bus.START        = poke_start && (i == 0);
      bus.SIZE_L_IN    = '0;
      tick();
      if (en_pat[i]) n++;
      check("cap_en", 64'(bus.H_IN_ENABLE), 64'(n == L));
      check("cap_error", 64'(bus.ERROR), 64'd0);
      if (n == L) break;
    end
    bus.H_OUT_ENABLE = 1'b0;
    bus.START        = 1'b0;
    if (bus.H_IN_ENABLE !== 1'b1) begin
      check("replay_entry", 64'(bus.H_IN_ENABLE), 64'd1);
      idle_inputs();
      return;
    end
    j = 0;
    k = 0;
    cyc = 0;
    forever begin
      check("rep_en", 64'(bus.H_IN_ENABLE), 64'd1);
      check("rep_data", bus.H_IN, data[j]);
      check("rep_ready_low", 64'(bus.READY), 64'd0);
      if (k < rdy_pat.size()) r = rdy_pat[k];
      else if (rand_rdy) r = ($urandom_range(0, 2) != 0);
      else r = 1'b1;
      k++;
      bus.H_IN_READY   = r;
      bus.H_OUT_ENABLE = ($urandom_range(0, 1) == 1);
      bus.H_OUT        = {$urandom, $urandom};
      bus.START        = poke_start && (cyc == 0);
      bus.SIZE_L_IN    = 64'd5;
      tick();
      cyc++;
      check("rep_error", 64'(bus.ERROR), 64'd0);
      if (r) j++;
      if (j == L) begin
        check("done_ready", 64'(bus.READY), 64'd1);
        check("done_en", 64'(bus.H_IN_ENABLE), 64'd0);
        check("done_hin", bus.H_IN, 64'd0);
        break;
      end
      if (cyc > 4 * L + 200) begin
        total++;
        $display("FAIL replay_timeout: got %0d transfers expected %0d", j, L);
        break;
      end
    end
    idle_inputs();
  endtask

  initial begin
    vec_t        vecs[6];
    logic [63:0] d[$];
    bit          ep[$];
    bit          rp[$];
    int unsigned L;

    vecs[0] = '{64'd0, 1'b1};
    vecs[1] = '{64'd65, 1'b1};
    vecs[2] = '{64'h1_0000_0004, 1'b1};
    vecs[3] = '{'1, 1'b1};
    vecs[4] = '{64'd1, 1'b0};
    vecs[5] = '{64'd64, 1'b0};

    RST = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_reset_outputs("por");
    #2 RST = 1'b0;
    tick();

    // Size legality table; every entry ends with an asynchronous reset.
    for (int i = 0; i < 6; i++) begin
      bus.START     = 1'b1;
      bus.SIZE_L_IN = vecs[i].size;
      tick();
      check("tbl_error", 64'(bus.ERROR), 64'(vecs[i].exp_error));
      check("tbl_en", 64'(bus.H_IN_ENABLE), 64'd0);
      bus.START = 1'b0;
      tick();
      check("tbl_error_pulse", 64'(bus.ERROR), 64'd0);
      check("tbl_en2", 64'(bus.H_IN_ENABLE), 64'd0);
      RST = 1'b1;
      #2;
      check_reset_outputs("tbl_rst");
      #2 RST = 1'b0;
      tick();
    end

    // L=4 contiguous
    d = '{64'h11, 64'h22, 64'h33, 64'h44};
    ep = '{1, 1, 1, 1};
    rp = '{1, 1, 1, 1};
    run(4, d, ep, rp, 1'b0, 1'b0);

    // L=3 gapped capture and stalled replay
    d = '{64'hA, 64'hB, 64'hC};
    ep = '{1, 0, 1, 0, 0, 1};
    rp = '{1, 0, 1, 1};
    run(3, d, ep, rp, 1'b0, 1'b0);
    tick();
    check("l3_ready_pulse", 64'(bus.READY), 64'd0);

    // L=L_MAX twice, back to back
    d = {};
    ep = {};
    rp = {};
    for (int i = 0; i < 64; i++) begin
      d.push_back(64'(i));
      ep.push_back(1'b1);
    end
    run(LM, d, ep, rp, 1'b0, 1'b0);
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(64'(100 + i));
    run(LM, d, ep, rp, 1'b0, 1'b0);

    // Reset partway through a capture, then a fresh L=2 run
    bus.START     = 1'b1;
    bus.SIZE_L_IN = 64'd5;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.H_OUT_ENABLE = 1'b1;
      bus.H_OUT        = 64'hDEAD_0000 + 64'(i);
      tick();
    end
    bus.H_OUT_ENABLE = 1'b0;
    RST = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    tick();
    check_reset_outputs("mid_rst_hold");
    #2 RST = 1'b0;
    tick();
    d = '{64'h5, 64'h6};
    ep = '{1, 1};
    rp = {};
    run(2, d, ep, rp, 1'b0, 1'b0);

    // L=1 with START poked during capture and replay
    d = '{64'h77};
    ep = '{1};
    run(1, d, ep, rp, 1'b0, 1'b1);
    tick();
    check("l1_idle_en", 64'(bus.H_IN_ENABLE), 64'd0);
    check("l1_ready_pulse", 64'(bus.READY), 64'd0);

    // Randomized runs with idle gaps carrying ignored H_OUT_ENABLE noise
    for (int t = 0; t < 40; t++) begin
      L = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : $urandom_range(1, LM);
      d = {};
      ep = {};
      rp = {};
      for (int i = 0; i < int'(L); i++) begin
        d.push_back({$urandom, $urandom});
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) ep.push_back(1'b0);
        ep.push_back(1'b1);
      end
      run(L, d, ep, rp, 1'b1, ($urandom_range(0, 3) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.H_OUT_ENABLE = ($urandom_range(0, 1) == 1);
        tick();
        check("gap_en", 64'(bus.H_IN_ENABLE), 64'd0);
      end
      bus.H_OUT_ENABLE = 1'b0;
    end

    tick();
    check("end_ready", 64'(bus.READY), 64'd0);
    check("end_en", 64'(bus.H_IN_ENABLE), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
